// File: rtl/isp_stat_awb_zone.sv
// Zoned AWB statistics: per-zone count of in-gate pixels plus R/G/B sums over a
// ZONE_H x ZONE_V grid, double-buffered so firmware reads a stable committed frame.
// Optional build macro STAT_AWB_ZONE_SATCLIP_EN: saturating accumulators and a
// sticky per-zone saturation flag returned in the MSB of the cnt word.
module isp_stat_awb_zone #(
  parameter int BITS     = 8,
  parameter int WIDTH    = 1280,
  parameter int HEIGHT   = 960,
  parameter int ZONE_H   = 4,
  parameter int ZONE_V   = 4,
  parameter int OUT_BITS = 32,
  localparam int AW      = $clog2(ZONE_H*ZONE_V)+2
) (
  input  logic                pclk,
  input  logic                rst_n,
  input  logic [BITS-1:0]     min,
  input  logic [BITS-1:0]     max,
  input  logic                in_href,
  input  logic                in_vsync,
  input  logic [BITS-1:0]     in_r,
  input  logic [BITS-1:0]     in_g,
  input  logic [BITS-1:0]     in_b,
  input  logic [AW-1:0]       rd_addr,
  output logic [OUT_BITS-1:0] rd_data,
  output logic                out_done,
  output logic                out_frame_err
);
  // state | meaning
  // IDLE  | accumulating; no shadow set waiting to be written
  // DRAIN | writing shadow zones of the finished zone row into the working bank
  localparam int NZ   = ZONE_H*ZONE_V;
  localparam int ZPIX = WIDTH/ZONE_H;
  localparam int ZLIN = HEIGHT/ZONE_V;
  localparam int XW   = $clog2(WIDTH+1);
  localparam int YW   = $clog2(HEIGHT+1);
  localparam int SW   = (ZPIX > 1) ? $clog2(ZPIX) : 1;
  localparam int LW   = (ZLIN > 1) ? $clog2(ZLIN) : 1;
  localparam int CW   = (ZONE_H > 1) ? $clog2(ZONE_H) : 1;
  localparam int ZRW  = $clog2(ZONE_V+1);
  localparam int RW   = $clog2(2*NZ);
`ifdef STAT_AWB_ZONE_SATCLIP_EN
  localparam int FW   = 1;
`else
  localparam int FW   = 0;
`endif
  localparam int EW   = 4*OUT_BITS+FW;
  localparam logic [RW-1:0] NZ_L = RW'(NZ);

  typedef enum logic {S_IDLE, S_DRAIN} state_t;

  state_t              state, state_nxt;
  logic                prev_vsync, prev_href;
  logic [XW-1:0]       x_cnt;
  logic [YW-1:0]       y_cnt;
  logic [SW-1:0]       sub_x;
  logic [LW-1:0]       line_sub;
  logic [CW-1:0]       col, drain_idx;
  logic [ZRW-1:0]      zrow;
  logic                bank_wr, swap_pending;
  logic [OUT_BITS-1:0] acc_cnt [ZONE_H];
  logic [OUT_BITS-1:0] acc_r   [ZONE_H];
  logic [OUT_BITS-1:0] acc_g   [ZONE_H];
  logic [OUT_BITS-1:0] acc_b   [ZONE_H];
  logic [OUT_BITS-1:0] sh_cnt  [ZONE_H];
  logic [OUT_BITS-1:0] sh_r    [ZONE_H];
  logic [OUT_BITS-1:0] sh_g    [ZONE_H];
  logic [OUT_BITS-1:0] sh_b    [ZONE_H];
`ifdef STAT_AWB_ZONE_SATCLIP_EN
  logic                acc_sat [ZONE_H];
  logic                sh_sat  [ZONE_H];
`endif
  logic [EW-1:0]       mem [2*NZ];

  logic frame_start, frame_end, href_fall, pix_ok, row_end;
  logic frame_done, swap_req, swap_now, drain_last;
  logic [RW-1:0]       wr_idx, rd_idx, rd_zone;
  logic [EW-1:0]       wr_entry, rd_entry;
  logic [OUT_BITS-1:0] rd_word;

`ifdef STAT_AWB_ZONE_SATCLIP_EN
  function automatic logic ovf(input logic [OUT_BITS-1:0] a, input logic [OUT_BITS-1:0] b);
    logic [OUT_BITS:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[OUT_BITS];
  endfunction
  function automatic logic [OUT_BITS-1:0] acc_add(input logic [OUT_BITS-1:0] a,
                                                  input logic [OUT_BITS-1:0] b);
    return ovf(a, b) ? '1 : a + b;
  endfunction
`else
  function automatic logic [OUT_BITS-1:0] acc_add(input logic [OUT_BITS-1:0] a,
                                                  input logic [OUT_BITS-1:0] b);
    return a + b;
  endfunction
`endif

  // Frame/line events, gating, and the swap decision (a swap waits for DRAIN to finish).
  always_comb begin
    frame_start = prev_vsync & ~in_vsync;
    frame_end   = ~prev_vsync & in_vsync;
    href_fall   = prev_href & ~in_href;
    pix_ok      = in_href && (x_cnt < XW'(WIDTH)) && (y_cnt < YW'(HEIGHT)) &&
                  (in_r >= min) && (in_r <= max) && (in_g >= min) && (in_g <= max) &&
                  (in_b >= min) && (in_b <= max);
    row_end     = href_fall && (line_sub == LW'(ZLIN-1)) && (y_cnt < YW'(HEIGHT));
    drain_last  = (state == S_DRAIN) && (drain_idx == CW'(ZONE_H-1));
    frame_done  = (zrow == ZRW'(ZONE_V)) ||
                  ((zrow == ZRW'(ZONE_V-1)) && ((state == S_DRAIN) || row_end));
    swap_req    = swap_pending || (frame_end && frame_done);
    swap_now    = swap_req && (((state == S_IDLE) && !row_end) || frame_start);
  end

  // FSM state register.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // FSM next state: enter DRAIN on zone-row end, leave after the last zone is written.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (row_end && !frame_start) state_nxt = S_DRAIN;
      S_DRAIN: if (frame_start || drain_last) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Position tracking: pixel/line counters and the zone column sub-counter.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      prev_vsync <= 1'b0;
      prev_href  <= 1'b0;
      x_cnt      <= '0;
      y_cnt      <= '0;
      sub_x      <= '0;
      col        <= '0;
      line_sub   <= '0;
    end else begin
      prev_vsync <= in_vsync;
      prev_href  <= in_href;
      if (frame_start) begin
        x_cnt    <= '0;
        y_cnt    <= '0;
        sub_x    <= '0;
        col      <= '0;
        line_sub <= '0;
      end else if (href_fall) begin
        x_cnt    <= '0;
        sub_x    <= '0;
        col      <= '0;
        if (y_cnt != YW'(HEIGHT)) y_cnt <= y_cnt + 1'b1;
        line_sub <= (line_sub == LW'(ZLIN-1)) ? '0 : line_sub + 1'b1;
      end else if (in_href) begin
        if (x_cnt != XW'(WIDTH)) x_cnt <= x_cnt + 1'b1;
        if (sub_x == SW'(ZPIX-1)) begin
          sub_x <= '0;
          if (col != CW'(ZONE_H-1)) col <= col + 1'b1;
        end else begin
          sub_x <= sub_x + 1'b1;
        end
      end
    end
  end

  // Drain progress, zone row index, bank select and event pulses.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      drain_idx     <= '0;
      zrow          <= '0;
      bank_wr       <= 1'b0;
      swap_pending  <= 1'b0;
      out_done      <= 1'b0;
      out_frame_err <= 1'b0;
    end else begin
      if (frame_start) begin
        drain_idx <= '0;
        zrow      <= '0;
      end else if (state == S_DRAIN) begin
        if (drain_last) begin
          drain_idx <= '0;
          zrow      <= zrow + 1'b1;
        end else begin
          drain_idx <= drain_idx + 1'b1;
        end
      end
      if (swap_now) bank_wr <= ~bank_wr;
      swap_pending  <= swap_req && !swap_now;
      out_done      <= swap_now;
      out_frame_err <= frame_end && !frame_done;
    end
  end

  // Per-column accumulators; cleared at frame start and when a zone row is handed to the shadow set.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ZONE_H; i++) begin
        acc_cnt[i] <= '0;
        acc_r[i]   <= '0;
        acc_g[i]   <= '0;
        acc_b[i]   <= '0;
`ifdef STAT_AWB_ZONE_SATCLIP_EN
        acc_sat[i] <= 1'b0;
`endif
      end
    end else if (frame_start || row_end) begin
      for (int i = 0; i < ZONE_H; i++) begin
        acc_cnt[i] <= '0;
        acc_r[i]   <= '0;
        acc_g[i]   <= '0;
        acc_b[i]   <= '0;
`ifdef STAT_AWB_ZONE_SATCLIP_EN
        acc_sat[i] <= 1'b0;
`endif
      end
    end else if (pix_ok) begin
      acc_cnt[col] <= acc_add(acc_cnt[col], OUT_BITS'(1));
      acc_r[col]   <= acc_add(acc_r[col], OUT_BITS'(in_r));
      acc_g[col]   <= acc_add(acc_g[col], OUT_BITS'(in_g));
      acc_b[col]   <= acc_add(acc_b[col], OUT_BITS'(in_b));
`ifdef STAT_AWB_ZONE_SATCLIP_EN
      acc_sat[col] <= acc_sat[col] | ovf(acc_cnt[col], OUT_BITS'(1)) |
                      ovf(acc_r[col], OUT_BITS'(in_r)) | ovf(acc_g[col], OUT_BITS'(in_g)) |
                      ovf(acc_b[col], OUT_BITS'(in_b));
`endif
    end
  end

  // Shadow set: snapshot of a finished zone row, held while DRAIN writes it out.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ZONE_H; i++) begin
        sh_cnt[i] <= '0;
        sh_r[i]   <= '0;
        sh_g[i]   <= '0;
        sh_b[i]   <= '0;
`ifdef STAT_AWB_ZONE_SATCLIP_EN
        sh_sat[i] <= 1'b0;
`endif
      end
    end else if (frame_start) begin
      for (int i = 0; i < ZONE_H; i++) begin
        sh_cnt[i] <= '0;
        sh_r[i]   <= '0;
        sh_g[i]   <= '0;
        sh_b[i]   <= '0;
`ifdef STAT_AWB_ZONE_SATCLIP_EN
        sh_sat[i] <= 1'b0;
`endif
      end
    end else if (row_end) begin
      for (int i = 0; i < ZONE_H; i++) begin
        sh_cnt[i] <= acc_cnt[i];
        sh_r[i]   <= acc_r[i];
        sh_g[i]   <= acc_g[i];
        sh_b[i]   <= acc_b[i];
`ifdef STAT_AWB_ZONE_SATCLIP_EN
        sh_sat[i] <= acc_sat[i];
`endif
      end
    end
  end

  // RAM addressing and word select; a read on the swap cycle already sees the new bank.
  always_comb begin
    wr_idx   = RW'(zrow) * RW'(ZONE_H) + RW'(drain_idx);
    if (bank_wr) wr_idx = wr_idx + NZ_L;
`ifdef STAT_AWB_ZONE_SATCLIP_EN
    wr_entry = {sh_sat[drain_idx], sh_b[drain_idx], sh_g[drain_idx], sh_r[drain_idx],
                sh_cnt[drain_idx]};
`else
    wr_entry = {sh_b[drain_idx], sh_g[drain_idx], sh_r[drain_idx], sh_cnt[drain_idx]};
`endif
    rd_zone  = RW'(rd_addr >> 2);
    rd_idx   = (swap_now ? bank_wr : ~bank_wr) ? rd_zone + NZ_L : rd_zone;
    rd_entry = mem[rd_idx];
    rd_word  = '0;
    case (rd_addr[1:0])
`ifdef STAT_AWB_ZONE_SATCLIP_EN
      2'd0: rd_word = {rd_entry[4*OUT_BITS], rd_entry[OUT_BITS-2:0]};
`else
      2'd0: rd_word = rd_entry[OUT_BITS-1:0];
`endif
      2'd1: rd_word = rd_entry[2*OUT_BITS-1:OUT_BITS];
      2'd2: rd_word = rd_entry[3*OUT_BITS-1:2*OUT_BITS];
      default: rd_word = rd_entry[4*OUT_BITS-1:3*OUT_BITS];
    endcase
  end

  // Zone RAM write, one zone entry per DRAIN cycle.
  always_ff @(posedge pclk) begin
    if ((state == S_DRAIN) && !frame_start) mem[wr_idx] <= wr_entry;
  end

  // Registered read port.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else        rd_data <= rd_word;
  end
endmodule

// File: doc/isp_stat_awb_zone.md
Name: isp_stat_awb_zone

Overview:
- Zoned AWB statistics block for the ISP-lite pipeline; a parametrised successor of the whole-frame AWB statistics unit.
- Splits the active frame into a ZONE_H x ZONE_V grid and accumulates, per zone, a count of in-range pixels and their R/G/B sums.
- Results are double-buffered: firmware reads a stable committed frame while the next frame accumulates.
- Sits after demosaic/CCM on the RGB stream, beside the histogram unit.

Parameters:
- BITS, 8: pixel component width.
- WIDTH, 1280: active pixels per line; must be divisible by ZONE_H.
- HEIGHT, 960: active lines per frame; must be divisible by ZONE_V.
- ZONE_H, 4: zone columns, 1..16.
- ZONE_V, 4: zone rows, 1..16.
- OUT_BITS, 32: width of each count/sum word.

Ports:
- pclk  in  1  pixel clock; all logic is in this domain.
- rst_n  in  1  asynchronous reset, active-low.
- min  in  BITS  inclusive lower gate, applied to all three components.
- max  in  BITS  inclusive upper gate, applied to all three components.
- in_href  in  1  line-valid.
- in_vsync  in  1  frame sync; high during blanking.
- in_r, in_g, in_b  in  BITS each  pixel components.
- rd_addr  in  AW=$clog2(ZONE_H*ZONE_V)+2  bits: [AW-1:2] zone index (row*ZONE_H+col); [1:0] word select, 0=cnt, 1=sum_r, 2=sum_g, 3=sum_b.
- rd_data  out  OUT_BITS  registered read data from the committed bank.
- out_done  out  1  one-cycle pulse when a new bank is committed.
- out_frame_err  out  1  one-cycle pulse when an incomplete frame is discarded.

Behaviour:
- Frame events:
  - frame_start = prev_vsync & ~in_vsync.
  - frame_end = ~prev_vsync & in_vsync.
  - prev_vsync resets to 0.
- frame_start clears x_cnt, y_cnt, col, zrow, all accumulators and the shadow set. It does not touch the committed bank.
- Position tracking:
  - x_cnt counts href-high cycles and clears on href fall.
  - y_cnt increments on each href fall.
  - Pixels with x_cnt >= WIDTH or y_cnt >= HEIGHT are ignored.
  - Zone column = x_cnt/(WIDTH/ZONE_H), tracked by a sub-counter; no divider.
- Gating: a pixel accumulates when href is high, it is in range, and min <= r,g,b <= max on every component. On accumulate, acc_cnt[col] += 1 and acc_sum_*[col] += component (zero-extended).
- Zone-row end: on the href fall that completes line (zrow+1)*HEIGHT/ZONE_V-1, in a single cycle:
  - all ZONE_H accumulator sets are copied to the shadow set;
  - the accumulators are cleared;
  - the FSM moves IDLE->DRAIN.
- DRAIN FSM:
  - Writes one zone per cycle (4 words as one 4*OUT_BITS entry) into the working bank at zrow*ZONE_H+i, for i = 0..ZONE_H-1.
  - Then returns to IDLE and increments zrow.
  - Latency from zone-row end to last write is ZONE_H+1 cycles.
  - Pixels arriving during DRAIN accumulate normally, because accumulators are independent of the shadow set.
- frame_end, complete frame (zrow==ZONE_V, or the drain of the last row is in progress):
  - Swap is deferred until DRAIN reaches IDLE.
  - Then committed bank <= working bank index and out_done pulses on the swap cycle.
- frame_end, incomplete frame (y_cnt != HEIGHT):
  - No swap; out_frame_err pulses for one cycle.
  - The working bank contents are don't-care and are overwritten next frame.
- frame_start arriving while a swap is pending: the pending swap executes first in that same cycle, then the clear.
- Read port:
  - rd_addr is sampled every cycle; rd_data = word of the committed bank, valid the next cycle.
  - A read issued on the swap cycle returns the newly committed bank.
- RAM: 2*ZONE_H*ZONE_V entries of 4*OUT_BITS, inferred.
- Reset values:
  - rd_data, out_done, out_frame_err = 0.
  - Committed bank = 1, working bank = 0.
  - RAM content is undefined until the first out_done; firmware must not read before it.
- Arithmetic: accumulators wrap modulo 2^OUT_BITS.

Optional Feature:
- STAT_AWB_ZONE_SATCLIP_EN defined:
  - every accumulator add saturates at 2^OUT_BITS-1;
  - an extra per-zone sticky sat flag is stored in the RAM entry;
  - the flag is returned in rd_data[OUT_BITS-1] of the cnt word, replacing cnt's MSB.
- Undefined: accumulators wrap silently and the cnt word is full-width.

Test Plan:
- Parameters for all cases: BITS=8, WIDTH=8, HEIGHT=4, ZONE_H=2, ZONE_V=2, OUT_BITS=16.
- Uniform frame: all pixels (r,g,b)=(10,20,30), min=0, max=255 -> out_done pulses once after vsync rises; each zone reads cnt=8, sum_r=80, sum_g=160, sum_b=240.
- Gating: zone 0 pixels r=5 with min=10, all other zones (50,50,50) -> zone 0 cnt=0 and sums 0; zones 1-3 cnt=8, sums 400.
- Short frame: only 3 lines, then vsync rises -> out_frame_err pulses, no out_done, rd_data still returns the previous frame's values.
- Late vsync: vsync rises 1 cycle after the last href fall -> out_done is delayed until DRAIN completes (ZONE_H+1 cycles); the zone 2/3 values are correct.
- Double buffer: read zone 3 sum_r continuously across two frames with values 100 then 200 per pixel -> rd_data reads 800 until the cycle after the second out_done, then 1600; it never shows a partial value.
- SATCLIP_EN, OUT_BITS=10: pixels 255 fill zone 0 (8 pixels, sum 2040) -> sum_r=1023, sat flag=1; without the macro, sum_r=2040 mod 1024=1016.
